axi_burst_beat_gen: RTL and testbench
=====================================

Name: axi_burst_beat_gen

Overview:
- Expands one AXI4 AR/AW burst descriptor (id, addr, len, size, burst) into a stream of per-beat addresses with valid/ready handshaking.
- Sits behind AXI slave front-ends (memories, peripheral bridges, width converters) that need the address of every beat.
- Successor to the shared fixed-width channel definitions: widths are parametrised, and it adds FIXED/INCR/WRAP address arithmetic and legality checking.

Parameters:
- AddrWidth, 64, address width in bits.
- IdWidth, 4, transaction ID width.
- DataWidth, 64, data bus width in bits; power of two, 8..1024. Sets the maximum legal size, MaxSize = log2(DataWidth/8).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous, active-high reset.
- req_valid_i  input  1  burst descriptor valid.
- req_ready_o  output  1  descriptor accepted when valid & ready.
- req_id_i  input  IdWidth  transaction ID.
- req_addr_i  input  AddrWidth  start address.
- req_len_i  input  8  beats minus one.
- req_size_i  input  3  log2 of bytes per beat.
- req_burst_i  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- beat_valid_o  output  1  beat valid.
- beat_ready_i  input  1  beat consumed.
- beat_id_o  output  IdWidth  ID of the current burst.
- beat_addr_o  output  AddrWidth  beat address.
- beat_idx_o  output  8  beat index, 0..len.
- beat_last_o  output  1  final beat of the burst.
- beat_err_o  output  1  burst is illegal; downstream answers SLVERR.

Behaviour:
- Reset: clk_i and rst_i as above (single clock, asynchronous active-high reset).
  - While rst_i is high, every output is 0, including req_ready_o. FSM goes to IDLE.
  - Asserting rst_i mid-burst aborts the burst immediately; remaining beats are discarded.
- FSM states: IDLE, BURST.
  - IDLE: req_ready_o=1, beat_valid_o=0.
  - On accept: go to BURST. Descriptor is registered and beat 0 is presented the next cycle (latency 1).
  - BURST: beat_valid_o=1. On a beat handshake, beat_idx_o increments and the address advances. On a handshake with beat_last_o=1, go to IDLE.
- Back-to-back: req_ready_o = IDLE | (beat_valid_o & beat_ready_i & beat_last_o).
  - A descriptor accepted in the same cycle as the last handshake is presented the next cycle with no bubble.
  - This is the only combinational input-to-output path.
- AXI stability: while beat_valid_o=1 and beat_ready_i=0, all beat_* outputs hold constant.
- beat_last_o = (beat_idx_o == len).
- Address arithmetic (bytes = 1<<size; all sums modulo 2^AddrWidth):
  - FIXED: every beat uses addr.
  - INCR: beat0 = addr, which may be unaligned. Beat n>0 = (addr & ~(bytes-1)) + n*bytes.
  - WRAP: window = (len+1)*bytes; lower = addr & ~(window-1). Next = cur+bytes, and if next == lower+window then next = lower.
- Legality, evaluated once at acceptance and held for the whole burst (err=1 if any condition holds):
  - size > MaxSize.
  - burst == 11.
  - WRAP with len not in {1,3,7,15}.
  - WRAP with addr not aligned to bytes.
  - INCR crossing 4 KiB: (addr[11:0] & ~(bytes-1)) + (len+1)*bytes > 4096.
- Erroneous bursts:
  - Still emit exactly len+1 beats so the response count stays AXI-correct.
  - beat_err_o=1 on every beat.
  - Addresses follow FIXED rules (all equal addr).
- len=0: a single beat with beat_last_o=1, for any burst type.
- Internal beat counter is 8 bits. len=255 must produce 256 beats without overflow misbehaviour.

Test Plan:
- INCR unaligned: addr 0x1003, size 2, len 3, ready always 1 -> addrs 0x1003, 0x1004, 0x1008, 0x100C; idx 0..3; last on idx 3; err 0; first beat 1 cycle after accept.
- WRAP: addr 0x1008, size 3, len 3 -> 0x1008, 0x1010, 0x1018, 0x1000; last on the 4th beat. Also len 2 -> err=1 on all 3 beats, each address 0x1008.
- FIXED + backpressure: addr 0x2000, size 3, len 2, beat_ready_i toggled 1-0-0-1-1 -> three beats at 0x2000; outputs stable during stalls; exactly 3 handshakes.
- 4 KiB crossing: addr 0xFF0, size 3, len 3 -> 4 beats at 0xFF0 with err=1. Also size 4 with DataWidth=64 -> err=1.
- Back-to-back: second descriptor held valid during the first burst's last beat -> accepted on the last handshake; its beat 0 valid the next cycle with no idle cycle. Then len=255 INCR -> 256 beats, last only on idx 255.
- Reset mid-burst: assert rst_i after beat 1 of a len-7 burst -> all outputs 0 asynchronously. After release, req_ready_o=1 and beat_valid_o=0; a new burst starts at idx 0.

Source files
------------

// File: rtl/axi_burst_beat_gen.sv
// axi_burst_beat_gen
// Expands one AXI4 AR/AW burst descriptor into a stream of per-beat addresses.
// A descriptor is accepted on req_valid_i & req_ready_o, and its beat 0 is
// presented on the following cycle. Beats are handed over on
// beat_valid_o & beat_ready_i.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o descriptor handshake
//   req_id_i                transaction ID
//   req_addr_i              start address
//   req_len_i               beats minus one
//   req_size_i              log2 of bytes per beat
//   req_burst_i             burst type: 00 FIXED, 01 INCR, 10 WRAP
//   beat_valid_o/beat_ready_i  beat handshake
//   beat_id_o               ID of the burst that is in progress
//   beat_addr_o             address of the current beat
//   beat_idx_o              index of the current beat
//   beat_last_o             set on the final beat
//   beat_err_o              burst is illegal; downstream answers SLVERR
module axi_burst_beat_gen #(
  parameter int AddrWidth = 64,
  parameter int IdWidth   = 4,
  parameter int DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [IdWidth-1:0]   req_id_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [7:0]           req_len_i,
  input  logic [2:0]           req_size_i,
  input  logic [1:0]           req_burst_i,
  output logic                 beat_valid_o,
  input  logic                 beat_ready_i,
  output logic [IdWidth-1:0]   beat_id_o,
  output logic [AddrWidth-1:0] beat_addr_o,
  output logic [7:0]           beat_idx_o,
  output logic                 beat_last_o,
  output logic                 beat_err_o
);

  localparam int         MaxSize   = $clog2(DataWidth / 8);
  localparam logic [3:0] MaxSizeL  = 4'(MaxSize);
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t               state, state_next;
  logic                 ready_int;
  logic                 accept, beat_hs, last_hs;

  logic [IdWidth-1:0]   id_reg;
  logic [AddrWidth-1:0] cur_addr, wrap_lower, wrap_upper;
  logic [7:0]           idx_reg, len_reg;
  logic [2:0]           size_reg;
  logic [1:0]           mode_reg;
  logic                 err_reg;

  // Descriptor decode (acceptance-time values)
  logic [AddrWidth-1:0] req_bytes, req_mask, req_window, req_lower;
  logic [16:0]          incr_span, incr_base;
  logic                 req_err, wrap_len_bad;

  // Per-beat address advance
  logic [AddrWidth-1:0] cur_bytes, cur_mask, wrap_sum, next_addr;

  assign beat_hs      = beat_valid_o & beat_ready_i;
  assign last_hs      = beat_hs & beat_last_o;
  // Reset forces the combinational ready low as well, so every output reads 0 during reset.
  assign req_ready_o  = ready_int & ~rst_i;
  assign accept       = req_valid_i & req_ready_o;

  assign beat_valid_o = (state == BURST);
  assign beat_id_o    = id_reg;
  assign beat_addr_o  = cur_addr;
  assign beat_idx_o   = idx_reg;
  // Gated by valid so that stale registers never show a last/err flag while idle.
  assign beat_last_o  = beat_valid_o & (idx_reg == len_reg);
  assign beat_err_o   = beat_valid_o & err_reg;

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and descriptor-ready generation
  always_comb begin
    state_next = state;
    ready_int  = 1'b0;
    case (state)
      IDLE: begin
        ready_int = 1'b1;
        if (req_valid_i) begin
          state_next = BURST;
        end else begin
          state_next = IDLE;
        end
      end
      BURST: begin
        if (last_hs) begin
          // A new descriptor taken on the final handshake continues without a bubble.
          ready_int  = 1'b1;
          state_next = req_valid_i ? BURST : IDLE;
        end else begin
          state_next = BURST;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Legality check and wrap window of the incoming descriptor
  always_comb begin
    req_bytes    = AddrWidth'(1) << req_size_i;
    req_mask     = req_bytes - AddrWidth'(1);
    req_window   = (AddrWidth'(req_len_i) + AddrWidth'(1)) << req_size_i;
    req_lower    = req_addr_i & ~(req_window - AddrWidth'(1));
    incr_base    = {5'd0, req_addr_i[11:0] & ~req_mask[11:0]};
    incr_span    = ({9'd0, req_len_i} + 17'd1) << req_size_i;
    wrap_len_bad = !((req_len_i == 8'd1) || (req_len_i == 8'd3) ||
                     (req_len_i == 8'd7) || (req_len_i == 8'd15));
    req_err      = 1'b0;
    if ({1'b0, req_size_i} > MaxSizeL) begin
      req_err = 1'b1;
    end else if (req_burst_i == 2'b11) begin
      req_err = 1'b1;
    end else if ((req_burst_i == BurstWrap) &&
                 (wrap_len_bad || ((req_addr_i & req_mask) != '0))) begin
      req_err = 1'b1;
    end else if ((req_burst_i == BurstIncr) && ((incr_base + incr_span) > 17'd4096)) begin
      req_err = 1'b1;
    end else begin
      req_err = 1'b0;
    end
  end

  // Address of the beat after the current one
  always_comb begin
    cur_bytes = AddrWidth'(1) << size_reg;
    cur_mask  = cur_bytes - AddrWidth'(1);
    wrap_sum  = cur_addr + cur_bytes;
    next_addr = cur_addr;
    case (mode_reg)
      BurstFixed: next_addr = cur_addr;
      // Aligning first makes an unaligned beat 0 step to the next aligned slot.
      BurstIncr:  next_addr = (cur_addr & ~cur_mask) + cur_bytes;
      BurstWrap:  next_addr = (wrap_sum == wrap_upper) ? wrap_lower : wrap_sum;
      default:    next_addr = cur_addr;
    endcase
  end

  // Burst context registers and beat counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_reg     <= '0;
      cur_addr   <= '0;
      wrap_lower <= '0;
      wrap_upper <= '0;
      idx_reg    <= 8'd0;
      len_reg    <= 8'd0;
      size_reg   <= 3'd0;
      mode_reg   <= 2'b00;
      err_reg    <= 1'b0;
    end else if (accept) begin
      id_reg     <= req_id_i;
      cur_addr   <= req_addr_i;
      wrap_lower <= req_lower;
      wrap_upper <= req_lower + req_window;
      idx_reg    <= 8'd0;
      len_reg    <= req_len_i;
      size_reg   <= req_size_i;
      // Illegal bursts still produce len+1 beats, all at the start address.
      mode_reg   <= req_err ? BurstFixed : req_burst_i;
      err_reg    <= req_err;
    end else if (beat_hs) begin
      if (beat_last_o) begin
        idx_reg <= 8'd0;
      end else begin
        idx_reg  <= idx_reg + 8'd1;
        cur_addr <= next_addr;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_beat_gen.sv
// Directed self-checking bench for axi_burst_beat_gen.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_axi_burst_beat_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_id;
  logic [63:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic [1:0]  req_burst;
  logic        beat_valid;
  logic        beat_ready;
  logic [3:0]  beat_id;
  logic [63:0] beat_addr;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic        beat_err;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt;

  axi_burst_beat_gen #(.AddrWidth(64), .IdWidth(4), .DataWidth(64)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_id_i    (req_id),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .req_size_i  (req_size),
    .req_burst_i (req_burst),
    .beat_valid_o(beat_valid),
    .beat_ready_i(beat_ready),
    .beat_id_o   (beat_id),
    .beat_addr_o (beat_addr),
    .beat_idx_o  (beat_idx),
    .beat_last_o (beat_last),
    .beat_err_o  (beat_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [3:0] id, input logic [63:0] addr,
                            input logic [7:0] idx, input logic last, input logic err);
    chk({tag, ".valid"}, 64'(beat_valid), 64'd1);
    chk({tag, ".id"},    64'(beat_id),    64'(id));
    chk({tag, ".addr"},  beat_addr,       addr);
    chk({tag, ".idx"},   64'(beat_idx),   64'(idx));
    chk({tag, ".last"},  64'(beat_last),  64'(last));
    chk({tag, ".err"},   64'(beat_err),   64'(err));
  endtask

  // Drive a descriptor from an idle state; returns on the edge where beat 0 must be visible.
  task automatic send(input string tag, input logic [3:0] id, input logic [63:0] addr,
                      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    @(negedge clk);
    req_valid = 1'b1;
    req_id    = id;
    req_addr  = addr;
    req_len   = len;
    req_size  = size;
    req_burst = burst;
    chk({tag, ".ready"}, 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".idle_valid"}, 64'(beat_valid), 64'd0);
    chk({tag, ".idle_ready"}, 64'(req_ready),  64'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_id     = 4'd0;
    req_addr   = 64'd0;
    req_len    = 8'd0;
    req_size   = 3'd0;
    req_burst  = 2'b00;
    beat_ready = 1'b1;

    // Reset state
    #12;
    chk("rst.ready", 64'(req_ready),  64'd0);
    chk("rst.valid", 64'(beat_valid), 64'd0);
    chk("rst.last",  64'(beat_last),  64'd0);
    chk("rst.addr",  beat_addr,       64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("post_rst");

    // INCR, unaligned start
    send("incr", 4'd1, 64'h1003, 8'd3, 3'd2, 2'b01);
    check_beat("incr0", 4'd1, 64'h1003, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_beat("incr1", 4'd1, 64'h1004, 8'd1, 1'b0, 1'b0);
    @(negedge clk);
    check_beat("incr2", 4'd1, 64'h1008, 8'd2, 1'b0, 1'b0);
    @(negedge clk);
    check_beat("incr3", 4'd1, 64'h100C, 8'd3, 1'b1, 1'b0);
    @(negedge clk);
    check_idle("incr_end");

    // WRAP, len 3
    send("wrap", 4'd2, 64'h1008, 8'd3, 3'd3, 2'b10);
    check_beat("wrap0", 4'd2, 64'h1008, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_beat("wrap1", 4'd2, 64'h1010, 8'd1, 1'b0, 1'b0);
    @(negedge clk);
    check_beat("wrap2", 4'd2, 64'h1018, 8'd2, 1'b0, 1'b0);
    @(negedge clk);
    check_beat("wrap3", 4'd2, 64'h1000, 8'd3, 1'b1, 1'b0);
    @(negedge clk);
    check_idle("wrap_end");

    // WRAP with illegal len 2
    send("wrapbad", 4'd3, 64'h1008, 8'd2, 3'd3, 2'b10);
    for (int i = 0; i < 3; i++) begin
      check_beat("wrapbad", 4'd3, 64'h1008, 8'(i), (i == 2), 1'b1);
      @(negedge clk);
    end
    check_idle("wrapbad_end");

    // FIXED with backpressure pattern 1-0-0-1-1
    send("fixed", 4'd4, 64'h2000, 8'd2, 3'd3, 2'b00);
    hs_cnt = 0;
    beat_ready = 1'b1;
    check_beat("fixA", 4'd4, 64'h2000, 8'd0, 1'b0, 1'b0);
    if (beat_valid && beat_ready) hs_cnt++;
    @(negedge clk);
    beat_ready = 1'b0;
    check_beat("fixB", 4'd4, 64'h2000, 8'd1, 1'b0, 1'b0);
    if (beat_valid && beat_ready) hs_cnt++;
    @(negedge clk);
    check_beat("fixC", 4'd4, 64'h2000, 8'd1, 1'b0, 1'b0);
    if (beat_valid && beat_ready) hs_cnt++;
    @(negedge clk);
    beat_ready = 1'b1;
    check_beat("fixD", 4'd4, 64'h2000, 8'd1, 1'b0, 1'b0);
    if (beat_valid && beat_ready) hs_cnt++;
    @(negedge clk);
    check_beat("fixE", 4'd4, 64'h2000, 8'd2, 1'b1, 1'b0);
    if (beat_valid && beat_ready) hs_cnt++;
    @(negedge clk);
    check_idle("fix_end");
    chk("fix.handshakes", 64'(hs_cnt), 64'd3);

    // INCR crossing 4 KiB
    send("cross", 4'd5, 64'hFF0, 8'd3, 3'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      check_beat("cross", 4'd5, 64'hFF0, 8'(i), (i == 3), 1'b1);
      @(negedge clk);
    end
    check_idle("cross_end");

    // Size wider than the data bus
    send("size", 4'd6, 64'h3000, 8'd1, 3'd4, 2'b01);
    check_beat("size0", 4'd6, 64'h3000, 8'd0, 1'b0, 1'b1);
    @(negedge clk);
    check_beat("size1", 4'd6, 64'h3000, 8'd1, 1'b1, 1'b1);
    @(negedge clk);
    check_idle("size_end");

    // len 0 on a WRAP burst type: single beat, flagged illegal
    send("len0", 4'd7, 64'h7000, 8'd0, 3'd2, 2'b10);
    check_beat("len0", 4'd7, 64'h7000, 8'd0, 1'b1, 1'b1);
    @(negedge clk);
    check_idle("len0_end");

    // Back-to-back into a 256-beat INCR
    send("b2b", 4'd2, 64'h4000, 8'd1, 3'd3, 2'b01);
    check_beat("b2b0", 4'd2, 64'h4000, 8'd0, 1'b0, 1'b0);
    chk("b2b.ready_mid", 64'(req_ready), 64'd0);
    @(negedge clk);
    req_valid = 1'b1;
    req_id    = 4'd9;
    req_addr  = 64'h0;
    req_len   = 8'd255;
    req_size  = 3'd0;
    req_burst = 2'b01;
    check_beat("b2b1", 4'd2, 64'h4008, 8'd1, 1'b1, 1'b0);
    chk("b2b.ready_last", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      check_beat("long", 4'd9, 64'(i), 8'(i), (i == 255), 1'b0);
      @(negedge clk);
    end
    check_idle("long_end");

    // Reset in the middle of a len-7 burst
    send("abort", 4'd3, 64'h5000, 8'd7, 3'd3, 2'b01);
    check_beat("abort0", 4'd3, 64'h5000, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_beat("abort1", 4'd3, 64'h5008, 8'd1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.ready", 64'(req_ready),  64'd0);
    chk("arst.valid", 64'(beat_valid), 64'd0);
    chk("arst.id",    64'(beat_id),    64'd0);
    chk("arst.addr",  beat_addr,       64'd0);
    chk("arst.idx",   64'(beat_idx),   64'd0);
    chk("arst.last",  64'(beat_last),  64'd0);
    chk("arst.err",   64'(beat_err),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("arst_rel");
    send("restart", 4'd1, 64'h6000, 8'd1, 3'd3, 2'b01);
    check_beat("restart0", 4'd1, 64'h6000, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_beat("restart1", 4'd1, 64'h6008, 8'd1, 1'b1, 1'b0);
    @(negedge clk);
    check_idle("restart_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
